instr_encoder: RTL and testbench

Sequential MIPS instruction encoder that runs in the opposite direction from the main decoder. It accepts instruction requests (an instruction class plus register and immediate fields) over a valid/ready handshake and packs each one into a 32-bit MIPS word. It writes the words to consecutive word addresses of the instruction-memory write port. It is the program loader used by self-test and boot paths to fill imem before the core leaves reset.

---
 rtl/instr_enc_pkg.sv | 47 ++++
 rtl/instr_enc_word.sv | 54 +++++
 rtl/instr_encoder.sv | 133 +++++++++++++
 tb/tb_instr_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - class codes, MIPS opcode/funct constants and FSM states for instr_encoder
package instr_enc_pkg;

    localparam logic [3:0] CLS_ADD   = 4'd0;
    localparam logic [3:0] CLS_SUB   = 4'd1;
    localparam logic [3:0] CLS_AND   = 4'd2;
    localparam logic [3:0] CLS_OR    = 4'd3;
    localparam logic [3:0] CLS_SLT   = 4'd4;
    localparam logic [3:0] CLS_J     = 4'd5;
    localparam logic [3:0] CLS_BEQ   = 4'd6;
    localparam logic [3:0] CLS_ADDI  = 4'd7;
    localparam logic [3:0] CLS_ADDIU = 4'd8;
    localparam logic [3:0] CLS_SLTI  = 4'd9;
    localparam logic [3:0] CLS_ANDI  = 4'd10;
    localparam logic [3:0] CLS_ORI   = 4'd11;
    localparam logic [3:0] CLS_XORI  = 4'd12;
    localparam logic [3:0] CLS_LUI   = 4'd13;
    localparam logic [3:0] CLS_LW    = 4'd14;
    localparam logic [3:0] CLS_SW    = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_SLOT = 1'b1
    } state_t;

endpackage

// File: rtl/instr_enc_word.sv
// rtl/instr_enc_word.sv - combinational packer from request fields to a 32-bit MIPS word
module instr_enc_word
    import instr_enc_pkg::*;
(
    input  logic [3:0]  i_cls,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word
);

    logic [5:0] w_op;
    logic [5:0] w_funct;

    always_comb begin
        w_op    = OP_RTYPE;
        w_funct = FN_ADD;
        case (i_cls)
            CLS_ADD:   w_funct = FN_ADD;
            CLS_SUB:   w_funct = FN_SUB;
            CLS_AND:   w_funct = FN_AND;
            CLS_OR:    w_funct = FN_OR;
            CLS_SLT:   w_funct = FN_SLT;
            CLS_J:     w_op = OP_J;
            CLS_BEQ:   w_op = OP_BEQ;
            CLS_ADDI:  w_op = OP_ADDI;
            CLS_ADDIU: w_op = OP_ADDIU;
            CLS_SLTI:  w_op = OP_SLTI;
            CLS_ANDI:  w_op = OP_ANDI;
            CLS_ORI:   w_op = OP_ORI;
            CLS_XORI:  w_op = OP_XORI;
            CLS_LUI:   w_op = OP_LUI;
            CLS_LW:    w_op = OP_LW;
            CLS_SW:    w_op = OP_SW;
            default:   w_op = OP_RTYPE;
        endcase
    end

    always_comb begin
        o_word = NOP_WORD;
        if (i_cls <= CLS_SLT) begin
            o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'b00000, w_funct};
        end else if (i_cls == CLS_J) begin
            o_word = {OP_J, i_target};
        end else if (i_cls == CLS_LUI) begin
            o_word = {w_op, 5'b00000, i_rt, i_imm};
        end else begin
            o_word = {w_op, i_rs, i_rt, i_imm};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - imem program loader: encodes requests into sequential word writes
// Optional branch delay-slot NOP insertion: INSTR_ENC_DELAY_SLOT_EN
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cls,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_V  = (ADDR_W+1)'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_alloc;
    logic [ADDR_W:0]     r_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wd;
    logic [31:0]         w_word;
    logic                w_full;
    logic                w_accept;
    logic                w_slot_go;

    instr_enc_word u_word (
        .i_cls    (in_cls),
        .i_rs     (in_rs),
        .i_rt     (in_rt),
        .i_rd     (in_rd),
        .i_imm    (in_imm),
        .i_target (in_target),
        .o_word   (w_word)
    );

    assign w_full   = (r_alloc == DEPTH_V);
    assign in_ready = !w_full && (r_state == S_RUN);
    assign w_accept = in_valid && in_ready;

`ifdef INSTR_ENC_DELAY_SLOT_EN
    logic w_branch;
    logic w_room2;
    logic r_err;

    assign w_branch  = (in_cls == CLS_J) || (in_cls == CLS_BEQ);
    assign w_room2   = (r_alloc < LAST_V);
    assign w_slot_go = w_accept && w_branch && w_room2;

    // Branch taking the very last slot: its NOP has nowhere to go.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_err <= 1'b0;
        end else if (w_accept && w_branch && !w_room2) begin
            r_err <= 1'b1;
        end
    end
    assign err = r_err;
`else
    assign w_slot_go = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_SLOT) begin
            w_state_nxt = S_RUN;
        end else if (w_slot_go) begin
            w_state_nxt = S_SLOT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alloc <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wd    <= '0;
        end else if (flush) begin
            r_alloc <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_state == S_SLOT) begin
                r_we    <= 1'b1;
                r_addr  <= r_addr + ADDR_W'(1);
                r_wd    <= NOP_WORD;
                r_count <= r_count + (ADDR_W+1)'(1);
            end else if (w_accept) begin
                r_we    <= 1'b1;
                r_addr  <= r_alloc[ADDR_W-1:0];
                r_wd    <= w_word;
                r_count <= r_count + (ADDR_W+1)'(1);
                r_alloc <= r_alloc + (w_slot_go ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
            end
        end
    end

    assign imem_we   = r_we;
    assign imem_addr = r_addr;
    assign imem_wd   = r_wd;
    assign count     = r_count;
    assign full      = w_full;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with a behavioural reference model
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef INSTR_ENC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cls;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cls    (in_cls),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] wd;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   m_alloc = 0;
    int   m_count = 0;
    bit   m_err   = 1'b0;
    bit   m_slot  = 1'b0;
    int   m_slot_addr = 0;

    int   op_tab[16] = '{0, 0, 0, 0, 0, 2, 4, 8, 9, 10, 12, 13, 14, 15, 35, 43};
    int   fn_tab[5]  = '{32, 34, 36, 37, 42};

    function automatic logic [31:0] ref_enc(int cls, int rs, int rt, int rd, int imm, int tgt);
        longint w;
        if (cls < 5)       w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn_tab[cls];
        else if (cls == 5) w = 64'd2 * 67108864 + tgt;
        else begin
            if (cls == 13) rs = 0;
            w = longint'(op_tab[cls]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
        end
        return w[31:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("imem_we", {31'd0, imem_we}, {31'd0, sb.size() > 0});
            if (imem_we && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("imem_addr", 32'(imem_addr), e.addr);
                chk("imem_wd", imem_wd, e.wd);
                chk("count_at_write", 32'(count), e.cnt);
            end
        end
    end

    task automatic drive(bit v, bit f, int cls, int rs, int rt, int rd, int imm, int tgt);
        exp_t e;
        @(negedge clk);
        #1;
        chk("in_ready", {31'd0, in_ready}, (m_alloc < DEPTH) && !m_slot);
        chk("full", {31'd0, full}, m_alloc == DEPTH);
        chk("err", {31'd0, err}, m_err);
        chk("count", 32'(count), m_count);
        in_valid  = v;
        flush     = f;
        in_cls    = 4'(cls);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        @(posedge clk);
        if (f) begin
            m_alloc = 0; m_count = 0; m_err = 1'b0; m_slot = 1'b0;
        end else if (m_slot) begin
            m_count++;
            e.addr = m_slot_addr; e.wd = 32'd0; e.cnt = m_count;
            sb.push_back(e);
            m_slot = 1'b0;
        end else if (v && m_alloc < DEPTH) begin
            m_count++;
            e.addr = m_alloc; e.wd = ref_enc(cls, rs, rt, rd, imm, tgt); e.cnt = m_count;
            sb.push_back(e);
            if (DS && (cls == 5 || cls == 6)) begin
                if (m_alloc + 2 <= DEPTH) begin
                    m_slot = 1'b1;
                    m_slot_addr = m_alloc + 1;
                    m_alloc += 2;
                end else begin
                    m_err = 1'b1;
                    m_alloc += 1;
                end
            end else begin
                m_alloc += 1;
            end
        end
    endtask

    task automatic rnd_req(bit v, bit f, int cls);
        drive(v, f, cls, $urandom_range(31), $urandom_range(31), $urandom_range(31),
              $urandom_range(16'hFFFF), $urandom_range(26'h3FF_FFFF));
    endtask

    task automatic do_flush();
        rnd_req(1'b1, 1'b1, $urandom_range(15));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cls = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wd", imem_wd, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        drive(1, 0, 7, 1, 2, 0, 16'h0005, 0);
        drive(1, 0, 0, 3, 4, 5, 0, 0);
        drive(1, 0, 15, 29, 31, 0, 4, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_flush();
        drive(1, 0, 13, 7, 8, 0, 16'h1234, 0);
        drive(1, 0, 5, 0, 0, 0, 0, 26'h10);
        do_flush();

        for (int i = 0; i < 4; i++) rnd_req(1, 0, $urandom_range(4));
        rnd_req(1, 0, 7);
        rnd_req(1, 0, 14);
        do_flush();
        rnd_req(1, 0, 8);

        do_flush();
        for (int i = 0; i < 3; i++) rnd_req(1, 0, $urandom_range(4));
        drive(1, 0, 6, 1, 2, 0, 16'hFFFF, 0);
        rnd_req(1, 0, 7);
        rnd_req(0, 0, 0);
        do_flush();
        for (int i = 0; i < 2; i++) rnd_req(1, 0, 11);
        drive(1, 0, 6, 1, 2, 0, 16'hFFFF, 0);
        rnd_req(1, 0, 7);
        rnd_req(0, 0, 0);
        do_flush();
        drive(1, 0, 5, 0, 0, 0, 0, 26'h2A);
        rnd_req(1, 0, 9);
        rnd_req(1, 0, 12);

        for (int i = 0; i < 600; i++) begin
            rnd_req($urandom_range(99) < 70, $urandom_range(99) < 8, $urandom_range(15));
        end

        rnd_req(0, 0, 0);
        rnd_req(0, 0, 0);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
